// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types and helpers for the SPI burst register bank
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  localparam int CMD_RW_BIT = 7;

  // Sample on the rising spi_clk edge in modes 0 and 3, falling in modes 1 and 2.
  function automatic logic mode_sample_rising(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// rtl/spi_edge_detect.sv - spi_clk history and mode-qualified sample/shift edge pulses
module spi_edge_detect
  import spi_regbank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic cpol,
  input  logic cpha,
  output logic sample,
  output logic shift
);

  logic spi_clk_q;
  logic rise;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_clk_q <= 1'b0;
    end else begin
      spi_clk_q <= spi_clk;
    end
  end

  assign rise   = spi_clk & ~spi_clk_q;
  assign fall   = ~spi_clk & spi_clk_q;
  assign sample = mode_sample_rising(cpol, cpha) ? rise : fall;
  assign shift  = mode_sample_rising(cpol, cpha) ? fall : rise;

endmodule

// File: rtl/spi_regbank_burst.sv
// rtl/spi_regbank_burst.sv - SPI slave register bank with bursts, auto-increment and strobes
module spi_regbank_burst
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 16,
  parameter int NUM_STATUS = 16,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_W     = 7,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            cfg_wr_pulse,
  output logic [ADDR_W-1:0]               cfg_wr_addr,
  output logic                            status_rd_pulse,
  output logic                            busy
);

  if (REG_WIDTH != 8) begin : g_bad_width
    $error("spi_regbank_burst: REG_WIDTH must be 8");
  end
  if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
    $error("spi_regbank_burst: ADDR_W must be 1..7");
  end
  if (NUM_CFG < 1 || NUM_CFG + NUM_STATUS > (1 << ADDR_W)) begin : g_bad_map
    $error("spi_regbank_burst: register map does not fit the address space");
  end

  state_t                              state_q, state_d;
  logic [1:0]                          mode_q;
  logic                                cs_n_q;
  logic                                sample, shift;
  logic [2:0]                          bit_cnt;
  logic [REG_WIDTH-2:0]                shift_in;
  logic [REG_WIDTH-1:0]                byte_in;
  logic [REG_WIDTH-1:0]                shift_out;
  logic [REG_WIDTH-1:0]                load_byte;
  logic [ADDR_W-1:0]                   addr_q;
  logic [ADDR_W-1:0]                   load_addr;
  logic                                is_write, load_rw;
  logic                                load_is_status, wr_hit;
  logic                                rd_pending;
  logic                                byte_end, cmd_done, data_done;
  logic [NUM_CFG-1:0][REG_WIDTH-1:0]   cfg_q;

  spi_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .spi_clk(spi_clk),
    .cpol   (mode_q[1]),
    .cpha   (mode_q[0]),
    .sample (sample),
    .shift  (shift)
  );

  assign byte_in   = {shift_in, spi_mosi};
  assign byte_end  = !spi_cs_n && sample && (bit_cnt == 3'd7);
  assign cmd_done  = byte_end && (state_q == CMD);
  assign data_done = byte_end && (state_q == DATA);
  assign load_addr = cmd_done ? byte_in[ADDR_W-1:0] : addr_q + ADDR_W'(1);
  assign load_rw   = cmd_done ? byte_in[CMD_RW_BIT] : is_write;

  // Address decode sweeps the map so unmapped addresses fall through to 0x00.
  always_comb begin
    load_byte      = '0;
    load_is_status = 1'b0;
    wr_hit         = 1'b0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (load_addr == ADDR_W'(k)) load_byte = cfg_q[k];
      if (addr_q == ADDR_W'(k)) wr_hit = 1'b1;
    end
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (load_addr == ADDR_W'(NUM_CFG + k)) begin
        load_byte      = status_regs[k*REG_WIDTH +: REG_WIDTH];
        load_is_status = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (spi_cs_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_n_q) state_d = CMD;
        CMD:     if (cmd_done) state_d = DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q          <= 2'b00;
      cs_n_q          <= 1'b0;
      bit_cnt         <= '0;
      shift_in        <= '0;
      shift_out       <= '0;
      addr_q          <= '0;
      is_write        <= 1'b0;
      rd_pending      <= 1'b0;
      spi_miso        <= 1'b0;
      cfg_q           <= CFG_RESET;
      cfg_wr_pulse    <= 1'b0;
      cfg_wr_addr     <= '0;
      status_rd_pulse <= 1'b0;
    end else begin
      cs_n_q          <= spi_cs_n;
      cfg_wr_pulse    <= 1'b0;
      status_rd_pulse <= 1'b0;
      if (state_q == IDLE) mode_q <= mode;
      if (spi_cs_n || state_q == IDLE) begin
        bit_cnt    <= '0;
        spi_miso   <= 1'b0;
        shift_out  <= '0;
        rd_pending <= 1'b0;
      end else begin
        if (sample) begin
          shift_in <= byte_in[REG_WIDTH-2:0];
          bit_cnt  <= bit_cnt + 3'd1;
          // Status strobe fires once the master actually starts clocking the byte out.
          if (state_q == DATA && bit_cnt == 3'd0 && rd_pending) begin
            status_rd_pulse <= 1'b1;
            rd_pending      <= 1'b0;
          end
        end
        if (byte_end) begin
          addr_q     <= load_addr;
          is_write   <= load_rw;
          rd_pending <= !load_rw && load_is_status;
          if (load_rw) begin
            shift_out <= '0;
          end else if (!mode_q[0]) begin
            spi_miso  <= load_byte[REG_WIDTH-1];
            shift_out <= {load_byte[REG_WIDTH-2:0], 1'b0};
          end else begin
            shift_out <= load_byte;
          end
          if (data_done && is_write && wr_hit) begin
            for (int k = 0; k < NUM_CFG; k++) begin
              if (addr_q == ADDR_W'(k)) cfg_q[k] <= byte_in;
            end
            cfg_wr_pulse <= 1'b1;
            cfg_wr_addr  <= addr_q;
          end
        // CPHA=0 already presented the MSB at load, so the first shift edge of a byte is skipped.
        end else if (shift && state_q == DATA && (mode_q[0] || bit_cnt != 3'd0)) begin
          spi_miso  <= shift_out[REG_WIDTH-1];
          shift_out <= {shift_out[REG_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign config_regs = cfg_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_regbank_burst.sv
// tb/tb_spi_regbank_burst.sv - scoreboard bench for spi_regbank_burst against a byte-level model
module tb_spi_regbank_burst;

  localparam int NUM_CFG    = 16;
  localparam int NUM_STATUS = 16;
  localparam int ADDR_W     = 7;
  localparam logic [127:0] RST_IMG = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         spi_cs_n = 1'b1;
  logic         spi_clk = 1'b0;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic [127:0] config_regs;
  logic [127:0] status_regs;
  logic         cfg_wr_pulse;
  logic [6:0]   cfg_wr_addr;
  logic         status_rd_pulse;
  logic         busy;

  always #5 clk = ~clk;

  spi_regbank_burst #(
    .NUM_CFG   (NUM_CFG),
    .NUM_STATUS(NUM_STATUS),
    .REG_WIDTH (8),
    .ADDR_W    (ADDR_W),
    .CFG_RESET (RST_IMG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .spi_cs_n       (spi_cs_n),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .config_regs    (config_regs),
    .status_regs    (status_regs),
    .cfg_wr_pulse   (cfg_wr_pulse),
    .cfg_wr_addr    (cfg_wr_addr),
    .status_rd_pulse(status_rd_pulse),
    .busy           (busy)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]   model_cfg    [NUM_CFG];
  logic [7:0]   model_status [NUM_STATUS];
  logic [127:0] rst_img = RST_IMG;
  logic [14:0]  exp_wr [$];
  int           exp_rd [$];
  logic [7:0]   exp_miso [$];
  logic [7:0]   tx_q [$];
  logic [1:0]   cur_mode = 2'b00;
  int           half = 4;

  always_comb begin
    status_regs = '0;
    for (int k = 0; k < NUM_STATUS; k++) status_regs[k*8 +: 8] = model_status[k];
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: committed config writes.
  logic [14:0] wr_e;
  always @(negedge clk) begin
    if (!rst && cfg_wr_pulse) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got pulse addr %0d want no pulse", cfg_wr_addr);
      end else begin
        wr_e = exp_wr.pop_front();
        check("wr_addr", cfg_wr_addr, wr_e[14:8]);
        check("wr_data", config_regs[int'(wr_e[14:8])*8 +: 8], wr_e[7:0]);
      end
    end
  end

  // Monitor: status read strobes.
  always @(negedge clk) begin
    if (!rst && status_rd_pulse) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL rd_pulse: got unexpected pulse want none");
      end else begin
        void'(exp_rd.pop_front());
      end
    end
  end

  // Monitor: MISO sniffer, samples on the mode's sample edge like a real master.
  logic       sn_prev = 1'b0;
  int         sn_cnt = 0;
  logic [7:0] sn_sh = 8'h00;
  logic [7:0] sn_exp;
  always @(negedge clk) begin
    if (rst || spi_cs_n) begin
      sn_cnt  = 0;
      sn_prev = spi_clk;
    end else begin
      if (spi_clk != sn_prev && spi_clk == ~(cur_mode[1] ^ cur_mode[0])) begin
        sn_sh = {sn_sh[6:0], spi_miso};
        sn_cnt++;
        if (sn_cnt == 8) begin
          sn_cnt = 0;
          total++;
          if (exp_miso.size() == 0) begin
            bad++;
            $display("FAIL miso_unexpected: got byte %0h want none", sn_sh);
          end else begin
            sn_exp = exp_miso.pop_front();
            total--;
            check("miso_byte", sn_sh, sn_exp);
          end
        end
      end
      sn_prev = spi_clk;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (!cur_mode[0]) begin
      spi_mosi = b;
      tick(half);
      spi_clk = ~cur_mode[1];
      tick(half);
      spi_clk = cur_mode[1];
    end else begin
      spi_clk  = ~cur_mode[1];
      spi_mosi = b;
      tick(half);
      spi_clk = cur_mode[1];
      tick(half);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) send_bit(d[i]);
  endtask

  task automatic reset_model();
    for (int k = 0; k < NUM_CFG; k++) model_cfg[k] = rst_img[k*8 +: 8];
  endtask

  task automatic do_xfer(input logic [1:0] m, input logic rw, input logic [6:0] start,
                         input int nbytes, input int partial, input bit use_reset,
                         input bit scramble);
    logic [7:0] cmd, d, e;
    int a;
    mode     = m;
    cur_mode = m;
    spi_clk  = m[1];
    half     = 4 + $urandom_range(0, 2);
    tick(3);
    spi_cs_n = 1'b0;
    @(negedge clk) check("busy_before_cs_seen", busy, 1'b0);
    @(negedge clk) check("busy_after_cs", busy, 1'b1);
    @(posedge clk) #1;
    if (scramble) mode = 2'($urandom);
    cmd = {rw, start};
    exp_miso.push_back(8'h00);
    send_byte(cmd, 8);
    for (int i = 0; i < nbytes; i++) begin
      a = (int'(start) + i) % 128;
      if (tx_q.size() != 0) d = tx_q.pop_front();
      else d = 8'($urandom);
      if (rw) begin
        if (a < NUM_CFG) begin
          model_cfg[a] = d;
          exp_wr.push_back({a[6:0], d});
        end
        exp_miso.push_back(8'h00);
      end else begin
        if (a < NUM_CFG) e = model_cfg[a];
        else if (a < NUM_CFG + NUM_STATUS) begin
          e = model_status[a - NUM_CFG];
          exp_rd.push_back(a);
        end else e = 8'h00;
        exp_miso.push_back(e);
      end
      send_byte(d, 8);
    end
    if (partial > 0) begin
      d = 8'($urandom);
      send_byte(d, partial);
    end
    tick(half);
    if (use_reset) begin
      rst = 1'b1;
      tick(2);
      spi_cs_n = 1'b1;
      tick(1);
      rst = 1'b0;
      reset_model();
      @(negedge clk);
      check("rst_config", config_regs, RST_IMG);
      check("rst_busy", busy, 1'b0);
      check("rst_miso", spi_miso, 1'b0);
      @(posedge clk) #1;
    end else begin
      spi_cs_n = 1'b1;
      @(negedge clk) check("busy_hold", busy, 1'b1);
      @(negedge clk) check("busy_release", busy, 1'b0);
      check("miso_idle", spi_miso, 1'b0);
      @(posedge clk) #1;
    end
    tick(3);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);
  endtask

  initial begin
    #5ms;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [127:0] img;
    for (int k = 0; k < NUM_STATUS; k++) model_status[k] = 8'($urandom);
    model_status[0] = 8'hCA;
    model_status[1] = 8'h10;
    reset_model();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_config", config_regs, RST_IMG);
    check("reset_miso", spi_miso, 1'b0);
    check("reset_wr_pulse", cfg_wr_pulse, 1'b0);
    check("reset_wr_addr", cfg_wr_addr, 7'd0);
    check("reset_rd_pulse", status_rd_pulse, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk) #1;

    tx_q.push_back(8'hA5);
    do_xfer(2'd0, 1'b1, 7'h03, 1, 0, 1'b0, 1'b0);
    check("mode0_reg3", config_regs[31:24], 8'hA5);

    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    do_xfer(2'd3, 1'b1, 7'h0E, 3, 0, 1'b0, 1'b0);
    check("mode3_reg14", config_regs[119:112], 8'h11);
    check("mode3_reg15", config_regs[127:120], 8'h22);

    do_xfer(2'd1, 1'b0, 7'h10, 2, 0, 1'b0, 1'b0);

    do_xfer(2'($urandom), 1'b0, 7'h7F, 2, 0, 1'b0, 1'b0);

    do_xfer(2'd0, 1'b1, 7'h05, 0, 4, 1'b0, 1'b0);
    check("abort_reg5", config_regs[47:40], model_cfg[5]);

    do_xfer(2'($urandom), 1'b1, 7'h02, 2, 3, 1'b1, 1'b0);
    tx_q.push_back(8'h3C);
    do_xfer(2'd2, 1'b1, 7'h07, 1, 0, 1'b0, 1'b0);
    check("mode2_reg7", config_regs[63:56], 8'h3C);
    do_xfer(2'd2, 1'b0, 7'h06, 3, 0, 1'b0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      logic [6:0] st;
      if ($urandom_range(0, 1) == 1) st = 7'($urandom_range(0, 35));
      else st = 7'($urandom_range(0, 127));
      do_xfer(2'($urandom), 1'($urandom), st, $urandom_range(1, 4), 0, 1'b0, 1'b1);
    end

    for (int k = 0; k < NUM_CFG; k++) img[k*8 +: 8] = model_cfg[k];
    check("final_config", config_regs, img);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
